// File: rtl/eeprom_access_seq.sv
`default_nettype none
// ============================================================================
// Module   : eeprom_access_seq
// Brief    : Turns one burst read/write request for a 24AA01-class EEPROM
//            into the byte-level command stream consumed by the I2C master.
// Revision : 1.0 - initial release
// ============================================================================
module eeprom_access_seq #(
   parameter logic [6:0] DEV_ADDR  = 7'b1010000,
   parameter int         LSIZE     = 8,
   parameter int         RETRY_MAX = 8
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_rd,
   input  logic [7:0]       req_addr,
   input  logic [LSIZE-1:0] req_len,
   input  logic [7:0]       wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic             done,
   output logic             err,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [2:0]       cmd_code,
   output logic [7:0]       cmd_data,
   input  logic             rsp_valid,
   input  logic             rsp_nack,
   input  logic [7:0]       rsp_data
);

   localparam int RETRY_W = $clog2(RETRY_MAX + 1);

   localparam logic [2:0] c_cmd_start = 3'd0;
   localparam logic [2:0] c_cmd_write = 3'd1;
   localparam logic [2:0] c_cmd_rack  = 3'd2;
   localparam logic [2:0] c_cmd_rnack = 3'd3;
   localparam logic [2:0] c_cmd_stop  = 3'd4;

   localparam logic [7:0]         c_dev_wr     = {DEV_ADDR, 1'b0};
   localparam logic [7:0]         c_dev_rd     = {DEV_ADDR, 1'b1};
   localparam logic [RETRY_W-1:0] c_retry_last = RETRY_W'(RETRY_MAX - 1);
   localparam logic [LSIZE-1:0]   c_len_one    = LSIZE'(1);
   localparam logic [LSIZE-1:0]   c_len_two    = LSIZE'(2);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_START  = 4'd1,
      S_DEVW   = 4'd2,
      S_WADDR  = 4'd3,
      S_WDATA  = 4'd4,
      S_RSTART = 4'd5,
      S_DEVR   = 4'd6,
      S_RDATA  = 4'd7,
      S_STOP   = 4'd8,
      S_DONE   = 4'd9
   } state_t;

   state_t             r_state;
   logic               r_rd;
   logic [7:0]         r_addr;
   logic [LSIZE-1:0]   r_len;
   logic [RETRY_W-1:0] r_retry;
   logic               r_busy;   // a command was accepted, its response is pending
   logic               r_fail;
   logic               r_poll;   // STOP belongs to an ACK-polling round, restart after it
   logic               w_rsp;

   assign req_ready = (r_state == S_IDLE);
   assign w_rsp     = r_busy && rsp_valid;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_rd      <= 1'b0;
         r_addr    <= '0;
         r_len     <= '0;
         r_retry   <= '0;
         r_busy    <= 1'b0;
         r_fail    <= 1'b0;
         r_poll    <= 1'b0;
         cmd_valid <= 1'b0;
         cmd_code  <= c_cmd_start;
         cmd_data  <= '0;
         wr_ready  <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         done     <= 1'b0;
         if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            r_busy    <= 1'b1;
         end
         if (w_rsp) r_busy <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_rd    <= req_rd;
                  r_addr  <= req_addr;
                  r_len   <= req_len;
                  r_retry <= '0;
                  r_fail  <= 1'b0;
                  r_poll  <= 1'b0;
                  if (req_len == '0) begin
                     err     <= 1'b1;
                     done    <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     err       <= 1'b0;
                     r_state   <= S_START;
                     cmd_valid <= 1'b1;
                     cmd_code  <= c_cmd_start;
                     cmd_data  <= '0;
                  end
               end
            end
            S_START: begin
               if (w_rsp) begin
                  r_state   <= S_DEVW;
                  cmd_valid <= 1'b1;
                  cmd_code  <= c_cmd_write;
                  cmd_data  <= c_dev_wr;
               end
            end
            S_DEVW: begin
               if (w_rsp) begin
                  cmd_valid <= 1'b1;
                  if (rsp_nack) begin
                     r_retry  <= r_retry + 1'b1;
                     r_fail   <= (r_retry == c_retry_last);
                     r_poll   <= (r_retry != c_retry_last);
                     r_state  <= S_STOP;
                     cmd_code <= c_cmd_stop;
                     cmd_data <= '0;
                  end else begin
                     r_state  <= S_WADDR;
                     cmd_code <= c_cmd_write;
                     cmd_data <= r_addr;
                  end
               end
            end
            S_WADDR: begin
               if (w_rsp) begin
                  if (rsp_nack) begin
                     r_fail    <= 1'b1;
                     r_state   <= S_STOP;
                     cmd_valid <= 1'b1;
                     cmd_code  <= c_cmd_stop;
                     cmd_data  <= '0;
                  end else if (r_rd) begin
                     r_state   <= S_RSTART;
                     cmd_valid <= 1'b1;
                     cmd_code  <= c_cmd_start;
                     cmd_data  <= '0;
                  end else begin
                     r_state  <= S_WDATA;
                     wr_ready <= 1'b1;
                  end
               end
            end
            S_WDATA: begin
               if (wr_valid && wr_ready) begin
                  wr_ready  <= 1'b0;
                  cmd_valid <= 1'b1;
                  cmd_code  <= c_cmd_write;
                  cmd_data  <= wr_data;
               end
               if (w_rsp) begin
                  if (rsp_nack || r_len == c_len_one) begin
                     r_fail    <= rsp_nack;
                     r_state   <= S_STOP;
                     cmd_valid <= 1'b1;
                     cmd_code  <= c_cmd_stop;
                     cmd_data  <= '0;
                  end else begin
                     wr_ready <= 1'b1;
                  end
                  r_len <= r_len - 1'b1;
               end
            end
            S_RSTART: begin
               if (w_rsp) begin
                  r_state   <= S_DEVR;
                  cmd_valid <= 1'b1;
                  cmd_code  <= c_cmd_write;
                  cmd_data  <= c_dev_rd;
               end
            end
            S_DEVR: begin
               if (w_rsp) begin
                  cmd_valid <= 1'b1;
                  cmd_data  <= '0;
                  if (rsp_nack) begin
                     r_fail   <= 1'b1;
                     r_state  <= S_STOP;
                     cmd_code <= c_cmd_stop;
                  end else begin
                     r_state  <= S_RDATA;
                     cmd_code <= (r_len == c_len_one) ? c_cmd_rnack : c_cmd_rack;
                  end
               end
            end
            S_RDATA: begin
               if (w_rsp) begin
                  rd_data   <= rsp_data;
                  rd_valid  <= 1'b1;
                  r_len     <= r_len - 1'b1;
                  cmd_valid <= 1'b1;
                  cmd_data  <= '0;
                  if (r_len == c_len_one) begin
                     r_state  <= S_STOP;
                     cmd_code <= c_cmd_stop;
                  end else begin
                     cmd_code <= (r_len == c_len_two) ? c_cmd_rnack : c_cmd_rack;
                  end
               end
            end
            S_STOP: begin
               if (w_rsp) begin
                  if (r_poll) begin
                     r_poll    <= 1'b0;
                     r_state   <= S_START;
                     cmd_valid <= 1'b1;
                     cmd_code  <= c_cmd_start;
                     cmd_data  <= '0;
                  end else begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                     err     <= r_fail;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_eeprom_access_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_eeprom_access_seq
// Brief    : Directed bench for eeprom_access_seq with a behavioural I2C master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eeprom_access_seq;

   logic       clock;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic       req_rd;
   logic [7:0] req_addr;
   logic [7:0] req_len;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       done;
   logic       err;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_code;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic       rsp_nack;
   logic [7:0] rsp_data;

   eeprom_access_seq #(
      .DEV_ADDR (7'b1010000),
      .LSIZE    (8),
      .RETRY_MAX(8)
   ) dut (
      .clock    (clock),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_rd   (req_rd),
      .req_addr (req_addr),
      .req_len  (req_len),
      .wr_data  (wr_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .done     (done),
      .err      (err),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_code (cmd_code),
      .cmd_data (cmd_data),
      .rsp_valid(rsp_valid),
      .rsp_nack (rsp_nack),
      .rsp_data (rsp_data)
   );

   localparam logic [10:0] E_START = 11'h000;
   localparam logic [10:0] E_RACK  = 11'h200;
   localparam logic [10:0] E_RNACK = 11'h300;
   localparam logic [10:0] E_STOP  = 11'h400;

   function automatic logic [10:0] ew(input logic [7:0] d);
      return {3'd1, d};
   endfunction

   int         checks = 0;
   int         passed = 0;
   logic [10:0] cmd_log[$];
   logic [7:0]  rd_log[$];
   logic [7:0]  wq[$];
   logic [7:0]  rd_src[$];
   int         wr_hs, done_cnt, cmd_seen, write_idx, nack_write_idx, devw_nack_left;
   logic       last_err;
   bit         rsp_due, rsp_nack_n, hs_flag, hold_addr, hold_seen;
   logic [7:0] rsp_data_n;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Behavioural master, write-byte source and output monitor, all at negedge.
   initial begin
      cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
      wr_valid = 1'b0; wr_data = 8'h00; rsp_due = 0; hs_flag = 0;
      hold_addr = 0; hold_seen = 0;
      forever begin
         @(negedge clock);
         if (rd_valid) rd_log.push_back(rd_data);
         if (done) begin done_cnt++; last_err = err; end
         if (cmd_valid) cmd_seen++;
         if (hs_flag) begin
            wr_hs++;
            if (wq.size() > 0) void'(wq.pop_front());
         end
         hs_flag  = wr_valid && wr_ready;
         wr_valid = (wq.size() > 0);
         wr_data  = (wq.size() > 0) ? wq[0] : 8'h00;

         rsp_valid = 1'b0;
         if (rsp_due) begin
            rsp_valid = 1'b1; rsp_nack = rsp_nack_n; rsp_data = rsp_data_n; rsp_due = 0;
         end else if (cmd_valid && hold_addr && cmd_code == 3'd1 && cmd_data == 8'h10) begin
            cmd_ready = 1'b0; hold_seen = 1;
         end else if (cmd_valid && cmd_ready) begin
            cmd_log.push_back({cmd_code, (cmd_code == 3'd1) ? cmd_data : 8'h00});
            rsp_due = 1; rsp_nack_n = 0; rsp_data_n = 8'h00;
            if (cmd_code == 3'd1) begin
               write_idx++;
               if (cmd_data == 8'hA0 && devw_nack_left > 0) begin
                  rsp_nack_n = 1; devw_nack_left--;
               end else if (write_idx == nack_write_idx) begin
                  rsp_nack_n = 1;
               end
            end else if (cmd_code == 3'd2 || cmd_code == 3'd3) begin
               if (rd_src.size() > 0) rsp_data_n = rd_src.pop_front();
               else rsp_data_n = 8'hEE;
            end
         end
      end
   end

   task automatic clear_tb();
      cmd_log.delete(); rd_log.delete(); wq.delete(); rd_src.delete();
      wr_hs = 0; done_cnt = 0; cmd_seen = 0; write_idx = 0;
      nack_write_idx = 0; devw_nack_left = 0; last_err = 1'bx;
   endtask

   task automatic start_req(input logic rd, input logic [7:0] addr, input logic [7:0] len);
      for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clock);
      req_valid = 1'b1; req_rd = rd; req_addr = addr; req_len = len;
      @(negedge clock);
      req_valid = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         if (done_cnt > 0) begin ok = 1; break; end
         @(negedge clock);
      end
      repeat (3) @(negedge clock);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_rd = 1'b0; req_addr = 8'h00; req_len = 8'h00;
      repeat (3) @(negedge clock);
      checks++; if (cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); else passed++;
      checks++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b want 0", wr_ready); else passed++;
      checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else passed++;
      checks++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL reset_done_err: got %b%b want 00", done, err); else passed++;
      checks++; if (cmd_code !== 3'd0 || cmd_data !== 8'h00) $display("FAIL reset_cmd: got %h/%h want 0/00", cmd_code, cmd_data); else passed++;
      checks++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", rd_data); else passed++;
      rst_n = 1'b1;
      @(negedge clock);
      checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else passed++;
   endtask

   task automatic test_write1();
      logic [10:0] exp[$];
      bit ok;
      clear_tb();
      wq.push_back(8'hA5);
      start_req(1'b0, 8'h10, 8'd1);
      wait_done(ok);
      exp = '{E_START, ew(8'hA0), ew(8'h10), ew(8'hA5), E_STOP};
      checks++; if (!ok) $display("FAIL write1_done: got no done want done"); else passed++;
      checks++; if (cmd_log.size() != exp.size()) $display("FAIL write1_ncmd: got %0d want %0d", cmd_log.size(), exp.size()); else passed++;
      for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (i >= cmd_log.size() || cmd_log[i] !== exp[i]) $display("FAIL write1_cmd%0d: got %h want %h", i, (i < cmd_log.size()) ? cmd_log[i] : 11'h7FF, exp[i]); else passed++;
      end
      checks++; if (wr_hs != 1) $display("FAIL write1_wr_hs: got %0d want 1", wr_hs); else passed++;
      checks++; if (last_err !== 1'b0) $display("FAIL write1_err: got %b want 0", last_err); else passed++;
   endtask

   task automatic test_read3();
      logic [10:0] exp[$];
      logic [7:0]  exp_rd[$];
      bit ok;
      clear_tb();
      rd_src = '{8'h11, 8'h22, 8'h33};
      start_req(1'b1, 8'h10, 8'd3);
      wait_done(ok);
      exp    = '{E_START, ew(8'hA0), ew(8'h10), E_START, ew(8'hA1), E_RACK, E_RACK, E_RNACK, E_STOP};
      exp_rd = '{8'h11, 8'h22, 8'h33};
      checks++; if (!ok) $display("FAIL read3_done: got no done want done"); else passed++;
      checks++; if (cmd_log.size() != exp.size()) $display("FAIL read3_ncmd: got %0d want %0d", cmd_log.size(), exp.size()); else passed++;
      for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (i >= cmd_log.size() || cmd_log[i] !== exp[i]) $display("FAIL read3_cmd%0d: got %h want %h", i, (i < cmd_log.size()) ? cmd_log[i] : 11'h7FF, exp[i]); else passed++;
      end
      checks++; if (rd_log.size() != 3) $display("FAIL read3_nrd: got %0d want 3", rd_log.size()); else passed++;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= rd_log.size() || rd_log[i] !== exp_rd[i]) $display("FAIL read3_rd%0d: got %h want %h", i, (i < rd_log.size()) ? rd_log[i] : 8'hXX, exp_rd[i]); else passed++;
      end
      checks++; if (last_err !== 1'b0) $display("FAIL read3_err: got %b want 0", last_err); else passed++;
   endtask

   task automatic test_ack_poll();
      logic [10:0] exp[$];
      bit ok;
      clear_tb();
      devw_nack_left = 2;
      wq.push_back(8'h5A);
      start_req(1'b0, 8'h10, 8'd1);
      wait_done(ok);
      exp = '{E_START, ew(8'hA0), E_STOP, E_START, ew(8'hA0), E_STOP,
              E_START, ew(8'hA0), ew(8'h10), ew(8'h5A), E_STOP};
      checks++; if (!ok) $display("FAIL poll2_done: got no done want done"); else passed++;
      checks++; if (cmd_log.size() != exp.size()) $display("FAIL poll2_ncmd: got %0d want %0d", cmd_log.size(), exp.size()); else passed++;
      for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (i >= cmd_log.size() || cmd_log[i] !== exp[i]) $display("FAIL poll2_cmd%0d: got %h want %h", i, (i < cmd_log.size()) ? cmd_log[i] : 11'h7FF, exp[i]); else passed++;
      end
      checks++; if (last_err !== 1'b0) $display("FAIL poll2_err: got %b want 0", last_err); else passed++;

      clear_tb();
      devw_nack_left = 8;
      wq.push_back(8'h5A);
      start_req(1'b0, 8'h10, 8'd1);
      wait_done(ok);
      exp.delete();
      for (int r = 0; r < 8; r++) begin
         exp.push_back(E_START); exp.push_back(ew(8'hA0)); exp.push_back(E_STOP);
      end
      checks++; if (!ok) $display("FAIL poll8_done: got no done want done"); else passed++;
      checks++; if (cmd_log.size() != exp.size()) $display("FAIL poll8_ncmd: got %0d want %0d", cmd_log.size(), exp.size()); else passed++;
      for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (i >= cmd_log.size() || cmd_log[i] !== exp[i]) $display("FAIL poll8_cmd%0d: got %h want %h", i, (i < cmd_log.size()) ? cmd_log[i] : 11'h7FF, exp[i]); else passed++;
      end
      checks++; if (wr_hs != 0) $display("FAIL poll8_wr_hs: got %0d want 0", wr_hs); else passed++;
      checks++; if (last_err !== 1'b1) $display("FAIL poll8_err: got %b want 1", last_err); else passed++;
   endtask

   task automatic test_data_nack();
      logic [10:0] exp[$];
      bit ok;
      clear_tb();
      wq = '{8'h01, 8'h02, 8'h03, 8'h04};
      nack_write_idx = 4;
      start_req(1'b0, 8'h20, 8'd4);
      wait_done(ok);
      exp = '{E_START, ew(8'hA0), ew(8'h20), ew(8'h01), ew(8'h02), E_STOP};
      checks++; if (!ok) $display("FAIL dnack_done: got no done want done"); else passed++;
      checks++; if (cmd_log.size() != exp.size()) $display("FAIL dnack_ncmd: got %0d want %0d", cmd_log.size(), exp.size()); else passed++;
      for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (i >= cmd_log.size() || cmd_log[i] !== exp[i]) $display("FAIL dnack_cmd%0d: got %h want %h", i, (i < cmd_log.size()) ? cmd_log[i] : 11'h7FF, exp[i]); else passed++;
      end
      checks++; if (wr_hs != 2) $display("FAIL dnack_wr_hs: got %0d want 2", wr_hs); else passed++;
      checks++; if (wr_ready !== 1'b0) $display("FAIL dnack_wr_ready: got %b want 0", wr_ready); else passed++;
      checks++; if (last_err !== 1'b1) $display("FAIL dnack_err: got %b want 1", last_err); else passed++;
   endtask

   task automatic test_len0();
      clear_tb();
      for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clock);
      req_valid = 1'b1; req_rd = 1'b0; req_addr = 8'h40; req_len = 8'd0;
      @(negedge clock);
      req_valid = 1'b0;
      checks++; if (done !== 1'b1 || err !== 1'b1) $display("FAIL len0_done_err: got %b%b want 11", done, err); else passed++;
      repeat (10) @(negedge clock);
      checks++; if (cmd_seen != 0 || cmd_log.size() != 0) $display("FAIL len0_no_cmd: got %0d cmd cycles want 0", cmd_seen); else passed++;
      checks++; if (done_cnt != 1) $display("FAIL len0_done_cnt: got %0d want 1", done_cnt); else passed++;
      checks++; if (req_ready !== 1'b1) $display("FAIL len0_req_ready: got %b want 1", req_ready); else passed++;
   endtask

   task automatic test_stall_reset();
      logic [10:0] exp[$];
      bit ok;
      clear_tb();
      hold_seen = 0;
      hold_addr = 1;
      wq.push_back(8'h77);
      start_req(1'b0, 8'h10, 8'd1);
      for (int i = 0; i < 100 && !hold_seen; i++) @(negedge clock);
      checks++; if (!hold_seen) $display("FAIL stall_reach_waddr: got no WADDR command want WADDR"); else passed++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         checks++;
         if (cmd_valid !== 1'b1 || cmd_code !== 3'd1 || cmd_data !== 8'h10)
            $display("FAIL stall_hold%0d: got v%b %h/%h want v1 1/10", i, cmd_valid, cmd_code, cmd_data);
         else passed++;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (cmd_valid !== 1'b0) $display("FAIL stall_rst_cmd_valid: got %b want 0", cmd_valid); else passed++;
      checks++; if (cmd_code !== 3'd0 || cmd_data !== 8'h00) $display("FAIL stall_rst_cmd: got %h/%h want 0/00", cmd_code, cmd_data); else passed++;
      hold_addr = 0; cmd_ready = 1'b1; rsp_due = 0;
      @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);
      checks++; if (req_ready !== 1'b1) $display("FAIL stall_req_ready: got %b want 1", req_ready); else passed++;

      clear_tb();
      wq.push_back(8'hC3);
      start_req(1'b0, 8'h30, 8'd1);
      wait_done(ok);
      exp = '{E_START, ew(8'hA0), ew(8'h30), ew(8'hC3), E_STOP};
      checks++; if (!ok) $display("FAIL after_rst_done: got no done want done"); else passed++;
      checks++; if (cmd_log.size() != exp.size()) $display("FAIL after_rst_ncmd: got %0d want %0d", cmd_log.size(), exp.size()); else passed++;
      for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (i >= cmd_log.size() || cmd_log[i] !== exp[i]) $display("FAIL after_rst_cmd%0d: got %h want %h", i, (i < cmd_log.size()) ? cmd_log[i] : 11'h7FF, exp[i]); else passed++;
      end
      checks++; if (last_err !== 1'b0) $display("FAIL after_rst_err: got %b want 0", last_err); else passed++;
   endtask

   initial begin
      clear_tb();
      test_reset();
      test_write1();
      test_read3();
      test_ack_poll();
      test_data_nack();
      test_len0();
      test_stall_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
